fft8_frame_ctrl: RTL
====================

FFT8_FRAME_CTRL -- requirements
Module: fft8_frame_ctrl

Interface
REQ-001 The block SHALL have parameter FFT_LAT, default 4, giving the cycles from core_in stable to core_out valid (3 butterfly stages plus the output register).
REQ-002 The block SHALL have parameter CW, default 32, giving the complex sample width: [31:16] real, [15:0] imaginary.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: rising-edge clock shared with the FFT core.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port s_valid, input, 1 bit: input sample valid.
REQ-007 Port s_ready, output, 1 bit: controller accepts an input sample.
REQ-008 Port s_data, input, CW bits: time-domain sample.
REQ-009 Port m_valid, output, 1 bit: output bin valid.
REQ-010 Port m_ready, input, 1 bit: downstream accepts an output bin.
REQ-011 Port m_data, output, CW bits: frequency bin.
REQ-012 Port m_last, output, 1 bit: marks bin 7 of a frame.
REQ-013 Port core_in, output, 8*CW bits: sample n on bits [CW*n +: CW], driven to the FFT core inputs in1..in8.
REQ-014 Port core_out, input, 8*CW bits: bin k on bits [CW*k +: CW], from the FFT core outputs out1..out8.
REQ-015 Port busy, output, 1 bit: high whenever the state is not LOAD.

Function
REQ-016 The FSM SHALL have three states, LOAD, WAIT and DRAIN, and SHALL hold one frame at a time with no overlap.
REQ-017 In LOAD, s_ready SHALL be 1; each s_valid&&s_ready SHALL write s_data into slot cnt of core_in and increment the 3-bit counter cnt.
REQ-018 When a sample is accepted with cnt==7, the FSM SHALL go to WAIT next cycle, clear cnt and load timer with FFT_LAT.
REQ-019 s_ready SHALL be 0 in WAIT and DRAIN, and s_valid SHALL be ignored there.
REQ-020 core_in SHALL change only on accepted writes and SHALL remain stable throughout WAIT and DRAIN.
REQ-021 In WAIT, timer SHALL decrement once per cycle; in the cycle timer==1, core_out SHALL be captured into the output buffer and the FSM SHALL go to DRAIN.
REQ-022 If the last input is accepted in cycle T, the first m_valid SHALL be asserted in cycle T+FFT_LAT+1.
REQ-023 In DRAIN, m_valid SHALL be 1, m_data SHALL equal buffer[idx] and m_last SHALL equal (idx==7).
REQ-024 In DRAIN, idx SHALL advance on m_valid&&m_ready.
REQ-025 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-026 Bins SHALL leave in natural order k=0..7, since the core already applies bit-reversed input mapping.
REQ-027 When bin 7 is accepted, the FSM SHALL return to LOAD and s_ready SHALL rise the next cycle; idx SHALL wrap to 0.
REQ-028 With m_ready held at 1, a frame SHALL drain in exactly 8 consecutive cycles.
REQ-029 FFT_LAT values below 1 SHALL be rejected at elaboration.

Reset
REQ-030 On rst_n=0, the block SHALL immediately enter LOAD with cnt=0, idx=0 and timer=0.
REQ-031 On rst_n=0, core_in and the output buffer SHALL become all 0.
REQ-032 On rst_n=0, outputs SHALL be s_ready=1, m_valid=0, m_data=0, m_last=0 and busy=0.
REQ-033 Reset mid-frame, in any state, SHALL discard the partial frame with no further outputs.
REQ-034 The first cycle after rst_n rises SHALL be able to accept a sample.

Configuration
REQ-035 With macro FFT8_FRAME_CTRL_STATS_EN defined, the block SHALL add output frame_cnt, 16 bits, reset to 0.
REQ-036 frame_cnt SHALL increment on acceptance of each m_last bin and wrap from 0xFFFF to 0x0000.
REQ-037 With FFT8_FRAME_CTRL_STATS_EN defined, the block SHALL add output overrun, 1 bit, a sticky flag reset to 0.
REQ-038 overrun SHALL be set when s_valid=1 while s_ready=0.
REQ-039 Without FFT8_FRAME_CTRL_STATS_EN, frame_cnt and overrun SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-040 Shared package fft8_pkg SHALL hold FFT_N=8, CW=32, the LOAD/WAIT/DRAIN state enum and the complex sample typedef.
REQ-041 The 8-entry output buffer, with write-all and read-by-index, SHALL be a sub-module fft8_frame_buf.
REQ-042 The FFT core SHALL be instantiated outside this block, and the block SHALL contain no arithmetic.

Verification
REQ-043 Identity stub core (core_out=core_in, delayed FFT_LAT=4), inputs 0x0000_0001..0x0000_0008 back-to-back -> busy rises; m_valid first at cycle T+5 after the last accept; m_data 0x0000_0001..0x0000_0008 on 8 consecutive cycles; m_last only on 0x0000_0008.
REQ-044 Real core, impulse s_data=0x0100_0000 then seven zeros -> all 8 bins equal 0x0100_0000 (unscaled core).
REQ-045 m_ready toggled 1,0,0,1 during DRAIN -> m_data frozen while m_ready=0; no bin lost or duplicated; 8 handshakes total.
REQ-046 s_valid held 1 through WAIT/DRAIN -> exactly 8 samples accepted per frame; with STATS_EN, overrun=1 and frame_cnt=1 after the frame.
REQ-047 rst_n pulsed low after 5 samples accepted -> outputs at reset values immediately; the next 8 samples form a clean frame whose result matches that frame only.
REQ-048 With STATS_EN, 65537 frames -> frame_cnt=0x0001.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared constants, FSM state encoding and complex sample layout for the 8-point FFT framing logic.
package fft8_pkg;

    localparam int unsigned FFT_N = 8;
    localparam int unsigned CW    = 32;
    localparam int unsigned IDX_W = $clog2(FFT_N);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fft8_state_e;

    // Real part in the upper half, imaginary part in the lower half.
    typedef struct packed {
        logic [CW/2-1:0] re;
        logic [CW/2-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft8_frame_buf.sv
// Eight-entry bin buffer: the whole FFT result is written in one cycle and read back one bin at a time.
module fft8_frame_buf
    import fft8_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [FFT_N*DW-1:0]   wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DW-1:0]         rd_data_c
);

    logic [FFT_N-1:0][DW-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (wr_en) begin
            mem_q <= wr_data;
        end
    end

    assign rd_data_c = mem_q[rd_idx];

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Frames a sample stream into 8-sample blocks for an external FFT core and streams the 8 bins back out.
// Define FFT8_FRAME_CTRL_STATS_EN to add the frame_cnt and overrun status outputs.
module fft8_frame_ctrl
    import fft8_pkg::*;
#(
    parameter int          FFT_LAT = 4,
    parameter int unsigned CW      = fft8_pkg::CW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CW-1:0]         s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CW-1:0]         m_data,
    output logic                  m_last,
    output logic [FFT_N*CW-1:0]   core_in,
    input  logic [FFT_N*CW-1:0]   core_out,
`ifdef FFT8_FRAME_CTRL_STATS_EN
    output logic [15:0]           frame_cnt,
    output logic                  overrun,
`endif
    output logic                  busy
);

    if (FFT_LAT < 1) begin : g_lat_chk
        $error("fft8_frame_ctrl: FFT_LAT must be at least 1");
    end

    localparam int unsigned TW = (FFT_LAT < 2) ? 1 : $clog2(FFT_LAT + 1);

    fft8_state_e            state_q;
    logic [IDX_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [TW-1:0]          timer_q;
    logic [FFT_N*CW-1:0]    core_in_q;
    logic                   s_ready_q;
    logic                   m_valid_q;
    logic                   m_last_q;
    logic                   busy_q;
    logic [CW-1:0]          m_data_q;

    logic                   s_acc_c;
    logic                   m_acc_c;
    logic                   cap_c;
    logic [IDX_W-1:0]       idx_nxt_c;
    logic [CW-1:0]          buf_rd_c;

    assign s_acc_c   = s_valid && s_ready_q;
    assign m_acc_c   = m_valid_q && m_ready;
    assign cap_c     = (state_q == WAIT) && (timer_q == TW'(1));
    assign idx_nxt_c = idx_q + IDX_W'(1);

    // The buffer is read one bin ahead so m_data can be registered on each handshake.
    fft8_frame_buf #(
        .DW (CW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (cap_c),
        .wr_data   (core_out),
        .rd_idx    (idx_nxt_c),
        .rd_data_c (buf_rd_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            core_in_q <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            m_data_q  <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (s_acc_c) begin
                        core_in_q[CW*cnt_q +: CW] <= s_data;
                        cnt_q <= cnt_q + IDX_W'(1);
                        if (cnt_q == IDX_W'(FFT_N - 1)) begin
                            state_q   <= WAIT;
                            cnt_q     <= '0;
                            timer_q   <= TW'(FFT_LAT);
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    timer_q <= timer_q - TW'(1);
                    // Bin 0 bypasses the buffer since it is being written this same edge.
                    if (cap_c) begin
                        state_q   <= DRAIN;
                        m_valid_q <= 1'b1;
                        m_data_q  <= core_out[CW-1:0];
                        m_last_q  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (m_acc_c) begin
                        if (idx_q == IDX_W'(FFT_N - 1)) begin
                            state_q   <= LOAD;
                            idx_q     <= '0;
                            m_valid_q <= 1'b0;
                            m_data_q  <= '0;
                            m_last_q  <= 1'b0;
                            s_ready_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            idx_q    <= idx_nxt_c;
                            m_data_q <= buf_rd_c;
                            m_last_q <= (idx_nxt_c == IDX_W'(FFT_N - 1));
                        end
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign core_in = core_in_q;
    assign busy    = busy_q;

`ifdef FFT8_FRAME_CTRL_STATS_EN
    logic [15:0] frame_cnt_q;
    logic        overrun_q;

    // Frame counter wraps naturally; overrun is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (m_acc_c && m_last_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (s_valid && !s_ready_q) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;
`endif

endmodule
